// File: rtl/ftq_pkg.sv
// Shared types and defaults for the fetch target queue.
// An entry describes one predicted fetch block. The slot field is sized for
// the widest supported fetch block; narrower configurations zero-extend.
package ftq_pkg;

    localparam int FTQ_DEPTH          = 16;
    localparam int SUPER_SCALAR_WIDTH = 4;
    localparam int FTQ_IDX_W          = $clog2(FTQ_DEPTH);
    localparam int FTQ_SLOT_MAX_W     = 8;

    // Index into the entry array, and pointer with an extra wrap bit so that
    // full and empty can be told apart.
    typedef logic [FTQ_IDX_W-1:0] ftq_idx_t;
    typedef logic [FTQ_IDX_W:0]   ftq_ptr_t;

    typedef struct packed {
        logic [63:0]               pc;
        logic                      taken;
        logic [FTQ_SLOT_MAX_W-1:0] slot;
        logic [63:0]               target;
    } ftq_entry_t;

endpackage

// File: rtl/ftq_mem.sv
// Entry storage for the fetch target queue: one enqueue write port, one
// resolve write port (rewrites the prediction fields of a mispredicted
// entry) and asynchronous read ports for fetch and resolve.
// A resolve write takes priority over an enqueue write to the same slot;
// the surrounding control never produces that collision.
module ftq_mem
    import ftq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk_in,
    input  logic              enq_we,
    input  logic [IDX_W-1:0]  enq_addr,
    input  ftq_entry_t        enq_data,
    input  logic              rs_we,
    input  logic [IDX_W-1:0]  rs_addr,
    input  logic              rs_taken,
    input  logic [SLOT_W-1:0] rs_slot,
    input  logic [63:0]       rs_target,
    input  logic [IDX_W-1:0]  fetch_addr,
    output logic [63:0]       fetch_pc,
    output logic              fetch_taken,
    output logic [SLOT_W-1:0] fetch_slot,
    output logic [63:0]       rs_pc
);

    ftq_entry_t mem [DEPTH];

    // Write ports; resolve rewrite overrides a same-address enqueue.
    always_ff @(posedge clk_in) begin
        if (enq_we && !(rs_we && (rs_addr == enq_addr))) begin
            mem[enq_addr] <= enq_data;
        end
        if (rs_we) begin
            mem[rs_addr].taken  <= rs_taken;
            mem[rs_addr].slot   <= FTQ_SLOT_MAX_W'(rs_slot);
            mem[rs_addr].target <= rs_target;
        end
    end

    assign fetch_pc    = mem[fetch_addr].pc;
    assign fetch_taken = mem[fetch_addr].taken;
    assign fetch_slot  = mem[fetch_addr].slot[SLOT_W-1:0];
    assign rs_pc       = mem[rs_addr].pc;

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: decouples the branch predictor from fetch and keeps
// every predicted block until the backend commits it, so a resolved
// mispredict can truncate younger blocks and issue a precise redirect.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. bp_ready_out depends on occupancy only. In a mispredict cycle the
// bp and fetch transfers are suppressed even when valid/ready are high.
//
// Optional build macro FTQ_BYPASS_EN: when nothing is waiting for fetch, an
// offered predictor block is presented to fetch in the same cycle.
module fetch_target_queue
    import ftq_pkg::*;
#(
    parameter int DEPTH       = FTQ_DEPTH,
    parameter int FETCH_WIDTH = SUPER_SCALAR_WIDTH,
    parameter int INSTR_BYTES = 4,
    parameter int IDX_W       = $clog2(DEPTH),
    parameter int SLOT_W      = $clog2(FETCH_WIDTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              bp_valid_in,
    output logic              bp_ready_out,
    input  logic [63:0]       bp_pc_in,
    input  logic              bp_taken_in,
    input  logic [SLOT_W-1:0] bp_slot_in,
    input  logic [63:0]       bp_target_in,
    output logic              fetch_valid_out,
    input  logic              fetch_ready_in,
    output logic [63:0]       fetch_pc_out,
    output logic              fetch_taken_out,
    output logic [SLOT_W-1:0] fetch_slot_out,
    output logic [IDX_W-1:0]  fetch_idx_out,
    input  logic              x_resolve_valid_in,
    input  logic [IDX_W-1:0]  x_idx_in,
    input  logic [SLOT_W-1:0] x_slot_in,
    input  logic              x_taken_in,
    input  logic              x_mispredict_in,
    input  logic [63:0]       x_target_in,
    input  logic              commit_valid_in,
    output logic              redirect_valid_out,
    output logic [63:0]       redirect_pc_out,
    output logic              upd_valid_out,
    output logic [63:0]       upd_pc_out,
    output logic              upd_taken_out,
    output logic [IDX_W:0]    count_out
);

    localparam logic [IDX_W:0] PTR_ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] PTR_DEPTH = (IDX_W+1)'(DEPTH);

    logic [IDX_W:0]   commit_ptr, fetch_ptr, enq_ptr;
    logic [IDX_W:0]   count, fetched_cnt, rewind_ptr;
    logic [IDX_W-1:0] rs_off;
    logic             full, queued, bypass;
    logic             rs_in_range, mispredict;
    logic             enq_fire, fetch_fire, commit_fire;
    ftq_entry_t       enq_entry;
    logic [63:0]      rd_pc, rs_pc;
    logic             rd_taken;
    logic [SLOT_W-1:0] rd_slot;

    assign count        = enq_ptr - commit_ptr;
    assign full         = (count == PTR_DEPTH);
    assign bp_ready_out = !full;
    assign count_out    = count;
    assign queued       = (fetch_ptr != enq_ptr);

    // A resolve is in range when its distance from the oldest entry is
    // smaller than the number of blocks already handed to fetch.
    assign rs_off      = x_idx_in - commit_ptr[IDX_W-1:0];
    assign fetched_cnt = fetch_ptr - commit_ptr;
    assign rs_in_range = x_resolve_valid_in && ({1'b0, rs_off} < fetched_cnt);
    assign mispredict  = rs_in_range && x_mispredict_in;
    // Rebuilding from commit_ptr keeps the wrap bit consistent with it.
    assign rewind_ptr  = commit_ptr + {1'b0, rs_off} + PTR_ONE;

`ifdef FTQ_BYPASS_EN
    assign bypass = !queued && !mispredict && bp_valid_in && bp_ready_out;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_valid_out = queued || bypass;
    assign enq_fire        = bp_valid_in && bp_ready_out && !mispredict;
    assign fetch_fire      = fetch_valid_out && fetch_ready_in && !mispredict;
    assign commit_fire     = commit_valid_in && (commit_ptr != fetch_ptr);

    // Pack the offered predictor block into an entry.
    always_comb begin
        enq_entry        = '0;
        enq_entry.pc     = bp_pc_in;
        enq_entry.taken  = bp_taken_in;
        enq_entry.slot   = FTQ_SLOT_MAX_W'(bp_slot_in);
        enq_entry.target = bp_target_in;
    end

    ftq_mem #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .SLOT_W (SLOT_W)
    ) u_mem (
        .clk_in      (clk_in),
        .enq_we      (enq_fire),
        .enq_addr    (enq_ptr[IDX_W-1:0]),
        .enq_data    (enq_entry),
        .rs_we       (mispredict),
        .rs_addr     (x_idx_in),
        .rs_taken    (x_taken_in),
        .rs_slot     (x_slot_in),
        .rs_target   (x_target_in),
        .fetch_addr  (fetch_ptr[IDX_W-1:0]),
        .fetch_pc    (rd_pc),
        .fetch_taken (rd_taken),
        .fetch_slot  (rd_slot),
        .rs_pc       (rs_pc)
    );

    // Fetch-side outputs: bypassed predictor block, queued entry, or zeros.
    always_comb begin
        fetch_pc_out    = '0;
        fetch_taken_out = 1'b0;
        fetch_slot_out  = '0;
        fetch_idx_out   = '0;
        if (bypass) begin
            fetch_pc_out    = bp_pc_in;
            fetch_taken_out = bp_taken_in;
            fetch_slot_out  = bp_slot_in;
            fetch_idx_out   = enq_ptr[IDX_W-1:0];
        end else if (queued) begin
            fetch_pc_out    = rd_pc;
            fetch_taken_out = rd_taken;
            fetch_slot_out  = rd_slot;
            fetch_idx_out   = fetch_ptr[IDX_W-1:0];
        end
    end

    // Pointer updates; a mispredict rewinds both producer-side pointers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            commit_ptr <= '0;
            fetch_ptr  <= '0;
            enq_ptr    <= '0;
        end else begin
            if (commit_fire) begin
                commit_ptr <= commit_ptr + PTR_ONE;
            end
            if (mispredict) begin
                enq_ptr   <= rewind_ptr;
                fetch_ptr <= rewind_ptr;
            end else begin
                if (enq_fire) begin
                    enq_ptr <= enq_ptr + PTR_ONE;
                end
                if (fetch_fire) begin
                    fetch_ptr <= fetch_ptr + PTR_ONE;
                end
            end
        end
    end

    // One-cycle training and redirect pulses derived from the resolve port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            upd_valid_out      <= 1'b0;
            upd_pc_out         <= '0;
            upd_taken_out      <= 1'b0;
            redirect_valid_out <= 1'b0;
            redirect_pc_out    <= '0;
        end else begin
            upd_valid_out      <= rs_in_range;
            redirect_valid_out <= mispredict;
            if (rs_in_range) begin
                upd_pc_out    <= rs_pc + 64'(x_slot_in) * 64'(INSTR_BYTES);
                upd_taken_out <= x_taken_in;
            end
            if (mispredict) begin
                redirect_pc_out <= x_taken_in ? x_target_in
                                 : rs_pc + (64'(x_slot_in) + 64'd1) * 64'(INSTR_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Self-checking bench for fetch_target_queue. The reference model tracks
// blocks by absolute sequence number (index = seq % DEPTH) in associative
// arrays; pointers are plain unbounded integers.
module tb_fetch_target_queue;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int SLOT_W = 2;

  // clock/reset block
  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic              bp_valid_in, bp_ready_out, bp_taken_in;
  logic [63:0]       bp_pc_in, bp_target_in;
  logic [SLOT_W-1:0] bp_slot_in;
  logic              fetch_valid_out, fetch_ready_in, fetch_taken_out;
  logic [63:0]       fetch_pc_out;
  logic [SLOT_W-1:0] fetch_slot_out;
  logic [IDX_W-1:0]  fetch_idx_out;
  logic              x_resolve_valid_in, x_taken_in, x_mispredict_in;
  logic [IDX_W-1:0]  x_idx_in;
  logic [SLOT_W-1:0] x_slot_in;
  logic [63:0]       x_target_in;
  logic              commit_valid_in;
  logic              redirect_valid_out, upd_valid_out, upd_taken_out;
  logic [63:0]       redirect_pc_out, upd_pc_out;
  logic [IDX_W:0]    count_out;

  fetch_target_queue dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .bp_valid_in(bp_valid_in), .bp_ready_out(bp_ready_out), .bp_pc_in(bp_pc_in),
    .bp_taken_in(bp_taken_in), .bp_slot_in(bp_slot_in), .bp_target_in(bp_target_in),
    .fetch_valid_out(fetch_valid_out), .fetch_ready_in(fetch_ready_in),
    .fetch_pc_out(fetch_pc_out), .fetch_taken_out(fetch_taken_out),
    .fetch_slot_out(fetch_slot_out), .fetch_idx_out(fetch_idx_out),
    .x_resolve_valid_in(x_resolve_valid_in), .x_idx_in(x_idx_in), .x_slot_in(x_slot_in),
    .x_taken_in(x_taken_in), .x_mispredict_in(x_mispredict_in), .x_target_in(x_target_in),
    .commit_valid_in(commit_valid_in),
    .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
    .upd_valid_out(upd_valid_out), .upd_pc_out(upd_pc_out), .upd_taken_out(upd_taken_out),
    .count_out(count_out)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_commit, m_fetch, m_enq;
  logic [63:0] m_pc [int];
  logic        m_taken [int];
  logic [1:0]  m_slot [int];
  logic [63:0] m_target [int];
  logic        m_upd_v, m_upd_t, m_red_v;
  logic [63:0] m_upd_pc, m_red_pc;

  // model view of the current cycle
  int          e_count, e_hit;
  logic        e_ready, e_fvalid, e_ftaken, e_misp, e_bypass;
  logic [63:0] e_fpc;
  logic [1:0]  e_fslot;
  logic [3:0]  e_fidx;

  initial begin
    m_commit = 0; m_fetch = 0; m_enq = 0;
    m_upd_v = 0; m_upd_t = 0; m_red_v = 0; m_upd_pc = 0; m_red_pc = 0;
  end

  // Combinational expectations from the current model state and inputs.
  task automatic model_comb();
    e_count = m_enq - m_commit;
    e_ready = (e_count < DEPTH);
    e_hit = -1;
    if (x_resolve_valid_in)
      for (int s = m_commit; s < m_fetch; s++)
        if (4'(s % DEPTH) == x_idx_in) e_hit = s;
    e_misp = (e_hit >= 0) && x_mispredict_in;
    e_bypass = 1'b0;
`ifdef FTQ_BYPASS_EN
    e_bypass = (m_fetch == m_enq) && !e_misp && bp_valid_in && e_ready;
`endif
    e_fvalid = (m_fetch != m_enq) || e_bypass;
    e_fpc = '0; e_ftaken = 1'b0; e_fslot = '0; e_fidx = '0;
    if (e_bypass) begin
      e_fpc = bp_pc_in; e_ftaken = bp_taken_in; e_fslot = bp_slot_in; e_fidx = 4'(m_enq % DEPTH);
    end else if (m_fetch != m_enq) begin
      e_fpc = m_pc[m_fetch]; e_ftaken = m_taken[m_fetch]; e_fslot = m_slot[m_fetch];
      e_fidx = 4'(m_fetch % DEPTH);
    end
  endtask

  // Advance the model by one clock with the current inputs.
  task automatic model_clock();
    logic do_commit;
    if (rst_in) begin
      m_commit = 0; m_fetch = 0; m_enq = 0; m_upd_v = 0; m_red_v = 0;
      m_pc.delete(); m_taken.delete(); m_slot.delete(); m_target.delete();
      return;
    end
    do_commit = commit_valid_in && (m_commit != m_fetch);
    m_upd_v = (e_hit >= 0);
    m_red_v = e_misp;
    if (e_hit >= 0) begin
      m_upd_pc = m_pc[e_hit] + 64'(x_slot_in) * 64'd4;
      m_upd_t = x_taken_in;
    end
    if (e_misp) begin
      m_red_pc = x_taken_in ? x_target_in : m_pc[e_hit] + (64'(x_slot_in) + 64'd1) * 64'd4;
      m_taken[e_hit] = x_taken_in; m_slot[e_hit] = x_slot_in; m_target[e_hit] = x_target_in;
      m_enq = e_hit + 1; m_fetch = e_hit + 1;
    end else begin
      if (bp_valid_in && e_ready) begin
        m_pc[m_enq] = bp_pc_in; m_taken[m_enq] = bp_taken_in;
        m_slot[m_enq] = bp_slot_in; m_target[m_enq] = bp_target_in;
      end
      if (e_fvalid && fetch_ready_in) m_fetch++;
      if (bp_valid_in && e_ready) m_enq++;
    end
    if (do_commit) m_commit++;
  endtask

  // driver tasks
  task automatic idle();
    bp_valid_in = 0; bp_pc_in = 0; bp_taken_in = 0; bp_slot_in = 0; bp_target_in = 0;
    fetch_ready_in = 0; x_resolve_valid_in = 0; x_idx_in = 0; x_slot_in = 0;
    x_taken_in = 0; x_mispredict_in = 0; x_target_in = 0; commit_valid_in = 0;
  endtask

  task automatic cycle_begin();
    @(negedge clk_in);
    model_comb();
  endtask

  task automatic cycle_end();
    model_clock();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1;
    repeat (2) begin cycle_begin(); cycle_end(); end
    rst_in = 0;
  endtask

  task automatic resolve(input logic [3:0] idx, input logic [1:0] slot, input logic tk,
                         input logic mp, input logic [63:0] tgt);
    x_resolve_valid_in = 1; x_idx_in = idx; x_slot_in = slot;
    x_taken_in = tk; x_mispredict_in = mp; x_target_in = tgt;
    cycle_begin(); cycle_end();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    cycle_begin();
    checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_out); end
    checks++; if (fetch_valid_out !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 0", fetch_valid_out); end
    checks++; if (bp_ready_out !== 1'b1) begin errors++; $display("FAIL reset_bp_ready: got %b expected 1", bp_ready_out); end
    checks++; if (redirect_valid_out !== 1'b0 || upd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_pulses: got redirect %b upd %b expected 0 0", redirect_valid_out, upd_valid_out); end
    checks++; if (fetch_pc_out !== 64'd0 || redirect_pc_out !== 64'd0 || upd_pc_out !== 64'd0) begin errors++; $display("FAIL reset_data: got fetch %h redirect %h upd %h expected 0", fetch_pc_out, redirect_pc_out, upd_pc_out); end
    cycle_end();
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bp_valid_in = 1; bp_pc_in = 64'h1000 + 64'(i) * 64'h40;
      cycle_begin(); cycle_end();
    end
    idle();
    cycle_begin();
    checks++; if (count_out !== 5'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", count_out); end
    cycle_end();
    fetch_ready_in = 1;
    for (int i = 0; i < 3; i++) begin
      cycle_begin();
      checks++; if (fetch_valid_out !== 1'b1 || fetch_pc_out !== 64'h1000 + 64'(i) * 64'h40 || fetch_idx_out !== 4'(i))
        begin errors++; $display("FAIL order_fetch%0d: got v=%b pc=%h idx=%0d expected v=1 pc=%h idx=%0d", i, fetch_valid_out, fetch_pc_out, fetch_idx_out, 64'h1000 + 64'(i) * 64'h40, i); end
      cycle_end();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    bp_valid_in = 1;
    for (int i = 0; i < 16; i++) begin
      bp_pc_in = 64'h4000 + 64'(i) * 64'h40;
      cycle_begin(); cycle_end();
    end
    bp_pc_in = 64'h5000;
    cycle_begin();
    checks++; if (bp_ready_out !== 1'b0 || count_out !== 5'd16) begin errors++; $display("FAIL full_state: got ready=%b count=%0d expected ready=0 count=16", bp_ready_out, count_out); end
    cycle_end();
    idle();
    cycle_begin();
    checks++; if (count_out !== 5'd16) begin errors++; $display("FAIL full_17th: got count=%0d expected 16", count_out); end
    cycle_end();
    fetch_ready_in = 1;
    cycle_begin();
    checks++; if (fetch_pc_out !== 64'h4000) begin errors++; $display("FAIL full_fetch: got %h expected 4000", fetch_pc_out); end
    cycle_end();
    idle(); commit_valid_in = 1;
    cycle_begin(); cycle_end();
    idle();
    cycle_begin();
    checks++; if (bp_ready_out !== 1'b1 || count_out !== 5'd15) begin errors++; $display("FAIL full_commit: got ready=%b count=%0d expected ready=1 count=15", bp_ready_out, count_out); end
    cycle_end();
  endtask

  task automatic test_resolve();
    do_reset();
    fetch_ready_in = 1;
    for (int i = 0; i < 9; i++) begin
      bp_valid_in = (i < 6);
      bp_pc_in = (i == 2) ? 64'h2000 : (i == 4) ? 64'h3000 : 64'h8000 + 64'(i) * 64'h40;
      cycle_begin(); cycle_end();
    end
    idle();
    resolve(4'd4, 2'd3, 1'b1, 1'b0, 64'h9000);
    cycle_begin();
    checks++; if (upd_valid_out !== 1'b1 || upd_pc_out !== 64'h300C || upd_taken_out !== 1'b1)
      begin errors++; $display("FAIL upd_pulse: got v=%b pc=%h t=%b expected v=1 pc=300c t=1", upd_valid_out, upd_pc_out, upd_taken_out); end
    checks++; if (redirect_valid_out !== 1'b0) begin errors++; $display("FAIL upd_no_redirect: got %b expected 0", redirect_valid_out); end
    cycle_end();
    cycle_begin();
    checks++; if (upd_valid_out !== 1'b0) begin errors++; $display("FAIL upd_one_cycle: got %b expected 0", upd_valid_out); end
    cycle_end();
    resolve(4'd2, 2'd1, 1'b0, 1'b1, 64'h9999);
    cycle_begin();
    checks++; if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'h2008)
      begin errors++; $display("FAIL misp_redirect: got v=%b pc=%h expected v=1 pc=2008", redirect_valid_out, redirect_pc_out); end
    checks++; if (count_out !== 5'd3 || fetch_valid_out !== 1'b0)
      begin errors++; $display("FAIL misp_truncate: got count=%0d fv=%b expected count=3 fv=0", count_out, fetch_valid_out); end
    cycle_end();
    bp_valid_in = 1; bp_pc_in = 64'h6000;
    cycle_begin(); cycle_end();
    idle();
    cycle_begin();
    checks++; if (fetch_valid_out !== 1'b1 || fetch_idx_out !== 4'd3 || redirect_valid_out !== 1'b0)
      begin errors++; $display("FAIL misp_next_idx: got fv=%b idx=%0d rv=%b expected fv=1 idx=3 rv=0", fetch_valid_out, fetch_idx_out, redirect_valid_out); end
    cycle_end();
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_ready_in = 1; commit_valid_in = 1;
    for (int c = 0; c < 200 && m_commit < 40; c++) begin
      bp_valid_in = (m_enq < 40); bp_pc_in = 64'h10000 + 64'(m_enq) * 64'h40;
      cycle_begin();
      checks++; if (fetch_valid_out !== e_fvalid || fetch_pc_out !== e_fpc || fetch_idx_out !== e_fidx || count_out !== 5'(e_count))
        begin errors++; $display("FAIL wrap_stream: got fv=%b pc=%h idx=%0d cnt=%0d expected fv=%b pc=%h idx=%0d cnt=%0d", fetch_valid_out, fetch_pc_out, fetch_idx_out, count_out, e_fvalid, e_fpc, e_fidx, e_count); end
      cycle_end();
    end
    idle();
    cycle_begin();
    checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL wrap_drain: got count=%0d expected 0", count_out); end
    cycle_end();
    fetch_ready_in = 1;
    for (int c = 0; c < 40 && m_fetch < 48; c++) begin
      bp_valid_in = (m_enq < 48); bp_pc_in = 64'h20000 + 64'(m_enq) * 64'h40;
      cycle_begin(); cycle_end();
    end
    idle();
    resolve(4'd15, 2'd0, 1'b1, 1'b1, 64'hABC0);
    cycle_begin();
    checks++; if (redirect_valid_out !== 1'b1 || redirect_pc_out !== 64'hABC0 || count_out !== 5'd8)
      begin errors++; $display("FAIL wrap_misp: got rv=%b pc=%h cnt=%0d expected rv=1 pc=abc0 cnt=8", redirect_valid_out, redirect_pc_out, count_out); end
    cycle_end();
    bp_valid_in = 1; bp_pc_in = 64'h7777_0000;
    cycle_begin(); cycle_end();
    idle();
    cycle_begin();
    checks++; if (fetch_valid_out !== 1'b1 || fetch_idx_out !== 4'd0 || count_out !== 5'd9)
      begin errors++; $display("FAIL wrap_next_idx: got fv=%b idx=%0d cnt=%0d expected fv=1 idx=0 cnt=9", fetch_valid_out, fetch_idx_out, count_out); end
    cycle_end();
  endtask

  task automatic test_ignored();
    do_reset();
    bp_valid_in = 1;
    for (int i = 0; i < 3; i++) begin bp_pc_in = 64'hC000 + 64'(i) * 64'h40; cycle_begin(); cycle_end(); end
    idle();
    resolve(4'd1, 2'd0, 1'b1, 1'b1, 64'h1234);
    cycle_begin();
    checks++; if (redirect_valid_out !== 1'b0 || upd_valid_out !== 1'b0 || count_out !== 5'd3 || fetch_idx_out !== 4'd0)
      begin errors++; $display("FAIL oor_resolve: got rv=%b uv=%b cnt=%0d idx=%0d expected 0 0 3 0", redirect_valid_out, upd_valid_out, count_out, fetch_idx_out); end
    cycle_end();
    commit_valid_in = 1;
    cycle_begin(); cycle_end();
    idle();
    cycle_begin();
    checks++; if (count_out !== 5'd3 || fetch_pc_out !== 64'hC000)
      begin errors++; $display("FAIL empty_commit: got cnt=%0d pc=%h expected cnt=3 pc=c000", count_out, fetch_pc_out); end
    cycle_end();
  endtask

  task automatic test_bypass();
    do_reset();
    bp_valid_in = 1; fetch_ready_in = 1; bp_pc_in = 64'hB000; bp_slot_in = 2'd2; bp_taken_in = 1;
    cycle_begin();
    checks++; if (fetch_valid_out !== e_fvalid || fetch_pc_out !== e_fpc || fetch_slot_out !== e_fslot || fetch_taken_out !== e_ftaken)
      begin errors++; $display("FAIL bypass_same_cycle: got fv=%b pc=%h expected fv=%b pc=%h", fetch_valid_out, fetch_pc_out, e_fvalid, e_fpc); end
    cycle_end();
    idle();
    cycle_begin();
    checks++; if (count_out !== 5'(e_count) || fetch_valid_out !== e_fvalid || fetch_pc_out !== e_fpc)
      begin errors++; $display("FAIL bypass_after: got cnt=%0d fv=%b pc=%h expected cnt=%0d fv=%b pc=%h", count_out, fetch_valid_out, fetch_pc_out, e_count, e_fvalid, e_fpc); end
    cycle_end();
  endtask

  task automatic test_random();
    int seq;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_in = ($urandom_range(0, 299) == 0);
      bp_valid_in = ($urandom_range(0, 3) != 0);
      bp_pc_in = {$urandom, $urandom} & ~64'h3;
      bp_taken_in = 1'($urandom); bp_slot_in = 2'($urandom); bp_target_in = {$urandom, $urandom};
      fetch_ready_in = ($urandom_range(0, 2) != 0);
      commit_valid_in = ($urandom_range(0, 2) == 0);
      x_resolve_valid_in = ($urandom_range(0, 3) == 0);
      if (m_fetch > m_commit && $urandom_range(0, 3) != 0) begin
        seq = $urandom_range(m_commit, m_fetch - 1);
        x_idx_in = 4'(seq % DEPTH);
      end else x_idx_in = 4'($urandom);
      x_mispredict_in = ($urandom_range(0, 2) == 0);
      x_slot_in = 2'($urandom); x_taken_in = 1'($urandom); x_target_in = {$urandom, $urandom};
      cycle_begin();
      checks++; if (bp_ready_out !== e_ready || count_out !== 5'(e_count))
        begin errors++; $display("FAIL rnd_occupancy c%0d: got rdy=%b cnt=%0d expected rdy=%b cnt=%0d", c, bp_ready_out, count_out, e_ready, e_count); end
      checks++; if (fetch_valid_out !== e_fvalid || fetch_pc_out !== e_fpc || fetch_taken_out !== e_ftaken || fetch_slot_out !== e_fslot || fetch_idx_out !== e_fidx)
        begin errors++; $display("FAIL rnd_fetch c%0d: got v=%b pc=%h t=%b s=%0d i=%0d expected v=%b pc=%h t=%b s=%0d i=%0d", c, fetch_valid_out, fetch_pc_out, fetch_taken_out, fetch_slot_out, fetch_idx_out, e_fvalid, e_fpc, e_ftaken, e_fslot, e_fidx); end
      checks++; if (upd_valid_out !== m_upd_v || (m_upd_v && (upd_pc_out !== m_upd_pc || upd_taken_out !== m_upd_t)))
        begin errors++; $display("FAIL rnd_upd c%0d: got v=%b pc=%h t=%b expected v=%b pc=%h t=%b", c, upd_valid_out, upd_pc_out, upd_taken_out, m_upd_v, m_upd_pc, m_upd_t); end
      checks++; if (redirect_valid_out !== m_red_v || (m_red_v && redirect_pc_out !== m_red_pc))
        begin errors++; $display("FAIL rnd_redirect c%0d: got v=%b pc=%h expected v=%b pc=%h", c, redirect_valid_out, redirect_pc_out, m_red_v, m_red_pc); end
      cycle_end();
    end
    rst_in = 0;
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_in = 1;
    test_reset();
    test_order();
    test_full();
    test_resolve();
    test_wrap();
    test_ignored();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
